// File: rtl/cache_trace_pkg.sv
// rtl/cache_trace_pkg.sv - shared op codes, FSM state type and trace entry record for the trace player
package cache_trace_pkg;

    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_WRITE = 8'h57;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        DONE
    } state_t;

    // Host-side view of one trace record at the default widths.
    typedef struct packed {
        logic [47:0] addr;
        logic [7:0]  op;
    } entry_t;

endpackage

// File: rtl/cache_trace_player_if.sv
// rtl/cache_trace_player_if.sv - request/response channel between the trace player and the cache
interface cache_trace_player_if #(
    parameter int ADDR_W = 48,
    parameter int OP_W   = 8
) ();
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [OP_W-1:0]   req_op;
    logic              rsp_valid;
    logic              rsp_hit;

    modport master (
        output req_valid, req_addr, req_op,
        input  req_ready, rsp_valid, rsp_hit
    );

    modport slave (
        input  req_valid, req_addr, req_op,
        output req_ready, rsp_valid, rsp_hit
    );
endinterface

// File: rtl/cache_trace_player_trace_ram.sv
// rtl/cache_trace_player_trace_ram.sv - trace storage: synchronous write, asynchronous read, no reset
module trace_ram #(
    parameter int DEPTH = 32,
    parameter int W     = 56,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [W-1:0]     wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [W-1:0]     rd_data
);
    logic [W-1:0] mem [DEPTH];
    logic         in_range;

    // Only a non-power-of-two depth can see an index past the last entry.
    if (DEPTH < (2 ** IDX_W)) begin : g_range
        assign in_range = ({1'b0, wr_idx} < (IDX_W+1)'(DEPTH));
    end else begin : g_full
        assign in_range = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en && in_range) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];
endmodule

// File: rtl/cache_trace_player.sv
// rtl/cache_trace_player.sv - replays a loaded (address, op) trace into the cache and gathers hit/miss statistics
module cache_trace_player
    import cache_trace_pkg::*;
#(
    parameter int ADDR_W = 48,
    parameter int OP_W   = 8,
    parameter int DEPTH  = 32,
    parameter int CNT_W  = 12,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_en,
    input  logic [IDX_W-1:0]     load_idx,
    input  logic [ADDR_W-1:0]    load_addr,
    input  logic [OP_W-1:0]      load_op,
    input  logic                 start,
    input  logic [IDX_W:0]       num_entries,
    cache_trace_player_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     num_reads,
    output logic [CNT_W-1:0]     num_writes,
    output logic [CNT_W-1:0]     num_hits,
    output logic [CNT_W-1:0]     num_misses,
    output logic [CNT_W-1:0]     num_bad_ops
);
    state_t                   state, state_n;
    logic [IDX_W:0]           len, len_in;
    logic [IDX_W-1:0]         idx;
    logic [ADDR_W+OP_W-1:0]   rd_word;
    logic [ADDR_W-1:0]        rd_addr;
    logic [OP_W-1:0]          rd_op;
    logic                     ram_we, op_is_read, op_is_write, last;
    logic                     do_start, cnt_bad, cnt_req, cnt_rsp, advance;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign len_in = (num_entries > (IDX_W+1)'(DEPTH)) ? (IDX_W+1)'(DEPTH) : num_entries;
    // A start in the same cycle wins over a load, and loads are locked out while replaying.
    assign ram_we = load_en && !start && (state == IDLE || state == DONE);

    trace_ram #(
        .DEPTH (DEPTH),
        .W     (ADDR_W + OP_W),
        .IDX_W (IDX_W)
    ) u_trace_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_idx  (load_idx),
        .wr_data ({load_addr, load_op}),
        .rd_idx  (idx),
        .rd_data (rd_word)
    );

    assign rd_addr     = rd_word[OP_W +: ADDR_W];
    assign rd_op       = rd_word[OP_W-1:0];
    assign op_is_read  = (rd_op == OP_W'(OP_READ));
    assign op_is_write = (rd_op == OP_W'(OP_WRITE));
    assign last        = ({1'b0, idx} == (len - 1'b1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n       = state;
        bus.req_valid = 1'b0;
        do_start      = 1'b0;
        cnt_bad       = 1'b0;
        cnt_req       = 1'b0;
        cnt_rsp       = 1'b0;
        advance       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    do_start = 1'b1;
                    state_n  = (len_in == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (!op_is_read && !op_is_write) begin
                    cnt_bad = 1'b1;
                    advance = 1'b1;
                    state_n = last ? DONE : ISSUE;
                end else begin
                    bus.req_valid = 1'b1;
                    if (bus.req_ready) begin
                        cnt_req = 1'b1;
                        state_n = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (bus.rsp_valid) begin
                    cnt_rsp = 1'b1;
                    advance = 1'b1;
                    state_n = last ? DONE : ISSUE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len         <= '0;
            idx         <= '0;
            num_reads   <= '0;
            num_writes  <= '0;
            num_hits    <= '0;
            num_misses  <= '0;
            num_bad_ops <= '0;
        end else if (do_start) begin
            len         <= len_in;
            idx         <= '0;
            num_reads   <= '0;
            num_writes  <= '0;
            num_hits    <= '0;
            num_misses  <= '0;
            num_bad_ops <= '0;
        end else begin
            if (cnt_bad) begin
                num_bad_ops <= sat_inc(num_bad_ops);
            end
            if (cnt_req && op_is_read) begin
                num_reads <= sat_inc(num_reads);
            end
            if (cnt_req && op_is_write) begin
                num_writes <= sat_inc(num_writes);
            end
            if (cnt_rsp && bus.rsp_hit) begin
                num_hits <= sat_inc(num_hits);
            end
            if (cnt_rsp && !bus.rsp_hit) begin
                num_misses <= sat_inc(num_misses);
            end
            if (advance && !last) begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign bus.req_addr = (state == ISSUE) ? rd_addr : '0;
    assign bus.req_op   = (state == ISSUE) ? rd_op : '0;
    assign busy         = (state == ISSUE) || (state == WAIT_RSP);
    assign done         = (state == DONE);
endmodule

// File: tb/tb_cache_trace_player.sv
// tb/tb_cache_trace_player.sv - directed and randomized replay checks against a trace-level reference model
module tb_cache_trace_player;
    localparam int AW = 48;
    localparam int OW = 8;
    localparam int DP = 32;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_en;
    logic [IW-1:0] load_idx;
    logic [AW-1:0] load_addr;
    logic [OW-1:0] load_op;
    logic          start, start_s;
    logic [IW:0]   num_entries;
    logic          busy, done, busy_s, done_s;
    logic [11:0]   n_r, n_w, n_h, n_m, n_b;
    logic [1:0]    s_r, s_w, s_h, s_m, s_b;

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] m_addr [DP];
    logic [OW-1:0] m_op   [DP];

    always #5 clk = ~clk;

    cache_trace_player_if #(.ADDR_W(AW), .OP_W(OW)) bus ();
    cache_trace_player_if #(.ADDR_W(AW), .OP_W(OW)) bus_s ();

    cache_trace_player #(.ADDR_W(AW), .OP_W(OW), .DEPTH(DP), .CNT_W(12)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_idx(load_idx),
        .load_addr(load_addr), .load_op(load_op), .start(start),
        .num_entries(num_entries), .bus(bus), .busy(busy), .done(done),
        .num_reads(n_r), .num_writes(n_w), .num_hits(n_h), .num_misses(n_m),
        .num_bad_ops(n_b)
    );

    cache_trace_player #(.ADDR_W(AW), .OP_W(OW), .DEPTH(DP), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .load_en(load_en), .load_idx(load_idx),
        .load_addr(load_addr), .load_op(load_op), .start(start_s),
        .num_entries(num_entries), .bus(bus_s), .busy(busy_s), .done(done_s),
        .num_reads(s_r), .num_writes(s_w), .num_hits(s_h), .num_misses(s_m),
        .num_bad_ops(s_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [7:0] op);
        return (op == 8'h52) || (op == 8'h57);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_entry(input int i, input logic [AW-1:0] a, input logic [OW-1:0] op);
        load_en   = 1'b1;
        load_idx  = IW'(i);
        load_addr = a;
        load_op   = op;
        tick();
        load_en   = 1'b0;
        m_addr[i] = a;
        m_op[i]   = op;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return AW'({$urandom(), $urandom()});
    endfunction

    // hit_mode: 0 = hit on even trace index, 1 = always hit, 2 = random
    task automatic run_replay(input int n, input int rdy_delay, input int rsp_delay,
                              input int hit_mode, input bit abort, input bit noise);
        int q[$];
        int len, exp_r, exp_w, exp_b, exp_h, exp_m, reqs, cnt, wt, cyc;
        bit pend, fin, hit;
        len = (n > DP) ? DP : n;
        exp_r = 0; exp_w = 0; exp_b = 0; exp_h = 0; exp_m = 0;
        reqs = 0; cnt = 0; wt = 0; cyc = 0; pend = 0; fin = 0;
        for (int i = 0; i < len; i++) begin
            if (!legal(m_op[i])) exp_b++;
            else begin
                q.push_back(i);
                if (m_op[i] == 8'h52) exp_r++; else exp_w++;
            end
        end
        start = 1'b1;
        num_entries = (IW+1)'(n);
        if (noise) begin
            load_en = 1'b1; load_idx = '0; load_addr = '0; load_op = 8'h41;
        end
        tick();
        start = 1'b0;
        load_en = 1'b0;
        chk("first_req_latency", bus.req_valid, (len > 0) && legal(m_op[0]));
        while (!fin && cyc < 3000) begin
            cyc++;
            bus.rsp_valid = 1'b0;
            bus.rsp_hit   = 1'b0;
            bus.req_ready = 1'b0;
            load_en   = noise && !done;
            load_idx  = IW'(cyc % DP);
            load_addr = '1;
            load_op   = 8'h41;
            if (done) begin
                fin = 1;
            end else if (pend) begin
                chk("one_outstanding", bus.req_valid, 1'b0);
                if (abort) begin
                    load_en = 1'b0;
                    reset = 1'b1;
                    #1;
                    chk("rst_busy", busy, 1'b0);
                    chk("rst_done", done, 1'b0);
                    chk("rst_req_valid", bus.req_valid, 1'b0);
                    chk("rst_reads_writes", {n_r, n_w}, '0);
                    chk("rst_hits_misses_bad", {n_h, n_m, n_b}, '0);
                    tick();
                    reset = 1'b0;
                    return;
                end
                cnt--;
                if (cnt <= 0) begin
                    case (hit_mode)
                        0: hit = (q[reqs-1] % 2) == 0;
                        1: hit = 1'b1;
                        default: hit = $urandom_range(0, 1) == 1;
                    endcase
                    bus.rsp_valid = 1'b1;
                    bus.rsp_hit   = hit;
                    if (hit) exp_h++; else exp_m++;
                    pend = 0;
                end
            end else if (bus.req_valid) begin
                if (reqs < q.size()) begin
                    chk("req_addr", bus.req_addr, m_addr[q[reqs]]);
                    chk("req_op", bus.req_op, m_op[q[reqs]]);
                end else begin
                    chk("req_count_excess", reqs + 1, q.size());
                end
                if (wt >= rdy_delay) begin
                    bus.req_ready = 1'b1;
                    pend = 1;
                    cnt  = rsp_delay;
                    reqs++;
                    wt   = 0;
                end else begin
                    wt++;
                end
            end else if (noise) begin
                // stray response while skipping an illegal entry must be ignored
                bus.rsp_valid = 1'b1;
                bus.rsp_hit   = 1'b1;
            end
            if (!fin) tick();
        end
        load_en = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.req_ready = 1'b0;
        chk("replay_finished", fin, 1'b1);
        if (len == 0) chk("zero_len_done_latency", cyc, 1);
        chk("done_held", done, 1'b1);
        chk("busy_clear", busy, 1'b0);
        chk("idle_req_valid", bus.req_valid, 1'b0);
        chk("num_requests", reqs, q.size());
        chk("num_reads", n_r, exp_r);
        chk("num_writes", n_w, exp_w);
        chk("num_bad_ops", n_b, exp_b);
        chk("num_hits", n_h, exp_h);
        chk("num_misses", n_m, exp_m);
        chk("inv_req_rsp", n_r + n_w, n_h + n_m);
        chk("inv_len", n_r + n_w + n_b, len);
    endtask

    initial begin
        int pat_w[20];
        bit pend_s;
        pat_w = '{1,0,1,1,0,0,0,0,1,1,1,0,0,1,0,1,0,1,0,0};
        reset = 1'b1;
        load_en = 1'b0; load_idx = '0; load_addr = '0; load_op = '0;
        start = 1'b0; start_s = 1'b0; num_entries = '0;
        bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_hit = 1'b0;
        bus_s.req_ready = 1'b0; bus_s.rsp_valid = 1'b0; bus_s.rsp_hit = 1'b0;
        tick();
        tick();
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_req", {bus.req_valid, bus.req_addr, bus.req_op}, '0);
        chk("reset_counters", {n_r, n_w, n_h, n_m, n_b}, '0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 20; i++) load_entry(i, rand_addr(), pat_w[i] ? 8'h57 : 8'h52);
        run_replay(20, 0, 2, 0, 0, 0);
        chk("t1_reads", n_r, 11);
        chk("t1_writes", n_w, 9);
        chk("t1_hits", n_h, 10);
        chk("t1_misses", n_m, 10);

        load_entry(2, rand_addr(), 8'h41);
        load_entry(5, rand_addr(), 8'h41);
        run_replay(6, 0, 2, 1, 0, 1);
        chk("t2_bad_ops", n_b, 2);
        chk("t2_req_total", n_r + n_w, 4);

        load_entry(2, rand_addr(), 8'h52);
        load_entry(5, rand_addr(), 8'h52);
        run_replay(6, 5, 2, 0, 0, 0);

        run_replay(0, 0, 1, 1, 0, 0);

        for (int i = 0; i < DP; i++) begin
            int r;
            r = $urandom_range(0, 9);
            load_entry(i, rand_addr(), (r < 4) ? 8'h52 : (r < 8) ? 8'h57 : OW'($urandom()));
        end
        run_replay(45, $urandom_range(0, 3), $urandom_range(1, 4), 2, 0, 1);

        load_entry(0, rand_addr(), 8'h52);
        run_replay(45, 0, 2, 2, 1, 0);
        run_replay(45, 1, 1, 2, 0, 0);

        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 6; j++) begin
                load_entry($urandom_range(0, DP - 1), rand_addr(),
                           ($urandom_range(0, 4) == 0) ? 8'h3f : (($urandom_range(0, 1) == 1) ? 8'h52 : 8'h57));
            end
            run_replay($urandom_range(1, 40), $urandom_range(0, 2), $urandom_range(1, 3), 2, 0, k == 1);
        end

        for (int i = 0; i < 8; i++) load_entry(i, rand_addr(), 8'h52);
        num_entries = 6'd8;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        pend_s = 0;
        for (int c = 0; c < 200 && !done_s; c++) begin
            bus_s.req_ready = 1'b1;
            bus_s.rsp_valid = 1'b0;
            bus_s.rsp_hit   = 1'b0;
            if (pend_s) begin
                bus_s.rsp_valid = 1'b1;
                bus_s.rsp_hit   = 1'b1;
                pend_s = 0;
            end else if (bus_s.req_valid) begin
                pend_s = 1;
            end
            tick();
        end
        bus_s.req_ready = 1'b0;
        bus_s.rsp_valid = 1'b0;
        chk("sat_done", done_s, 1'b1);
        chk("sat_reads", s_r, 2'd3);
        chk("sat_hits", s_h, 2'd3);
        chk("sat_writes_misses_bad", {s_w, s_m, s_b}, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_trace_player.md
Name: cache_trace_player

Overview:
- Synthesizable, parametrised trace sequencer that replays an (address, op) trace into the cache over a valid/ready request channel and accumulates read/write/hit/miss statistics.
- Generalises the fixed 20-entry, fixed-10-ns replay loop into:
  - loadable trace depth,
  - one-outstanding-request handshake,
  - illegal-op accounting,
  - saturating counters.
- Sits between a host/loader and cache_top.

Parameters:
- ADDR_W, 48, trace/cache address width.
- OP_W, 8, op code width (ASCII op codes).
- DEPTH, 32, trace entries stored.
- CNT_W, 12, statistics counter width.
- IDX_W, $clog2(DEPTH), entry index width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- load_en  in  1  write one trace entry this cycle.
- load_idx  in  IDX_W  entry index to write.
- load_addr  in  ADDR_W  entry address.
- load_op  in  OP_W  entry op code.
- start  in  1  begin replay of entries 0..num_entries-1 (pulse).
- num_entries  in  IDX_W+1  trace length, 0..DEPTH, sampled on start.
- req_valid  out  1  request to cache valid.
- req_ready  in  1  cache accepts request.
- req_addr  out  ADDR_W  request address.
- req_op  out  OP_W  request op (8'h52 R, 8'h57 W).
- rsp_valid  in  1  cache response for outstanding request.
- rsp_hit  in  1  1 = hit, 0 = miss; qualified by rsp_valid.
- busy  out  1  replay in progress.
- done  out  1  replay complete; held until next start.
- num_reads, num_writes, num_hits, num_misses  out  CNT_W each  statistics.
- num_bad_ops  out  CNT_W  entries skipped for illegal op.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; len/idx registers 0. Trace RAM contents are not reset.
- FSM states: IDLE, ISSUE, WAIT_RSP, DONE.
- IDLE:
  - load_en writes RAM[load_idx]; load_idx >= DEPTH is ignored.
  - start samples num_entries (values > DEPTH clamp to DEPTH), clears all counters, clears done, sets idx=0.
  - If num_entries==0, go to DONE; else go to ISSUE.
- Priority: start and load_en in the same cycle → start wins and the load is dropped.
- ISSUE:
  - Entry = RAM[idx], asynchronous read.
  - Op not 8'h52 and not 8'h57: no request; num_bad_ops++; advance idx.
  - Legal op: req_valid=1 with req_addr/req_op from the entry. On req_valid&&req_ready, count the op (reads++ or writes++) and go to WAIT_RSP.
  - req_valid, req_addr and req_op stay stable until accepted.
- WAIT_RSP:
  - req_valid=0.
  - On rsp_valid: hits++ if rsp_hit, else misses++; advance idx.
  - rsp_valid in any other state is ignored.
- Advance idx: if idx==len-1, go to DONE; else idx++ and go to ISSUE.
- Timing:
  - First req_valid is asserted the cycle after start.
  - Next req_valid is asserted the cycle after rsp_valid.
  - At most one request outstanding; rsp_valid in the same cycle as acceptance is not accepted.
- DONE: done=1, busy=0. start restarts the replay; loads are allowed.
- busy=1 in ISSUE and WAIT_RSP. load_en and start are ignored while busy.
- Counters saturate at all-ones and never wrap.
- Invariant on completion: reads+writes == hits+misses, and reads+writes+bad_ops == len (when unsaturated).
- Reset mid-replay: immediate return to IDLE with all outputs 0; RAM retained.

Decomposition:
- Package cache_trace_pkg:
  - OP_READ=8'h52, OP_WRITE=8'h57.
  - state_t enum (IDLE, ISSUE, WAIT_RSP, DONE).
  - Entry struct {addr, op}.
- Sub-module trace_ram:
  - DEPTH x (ADDR_W+OP_W).
  - Synchronous write, asynchronous read.
  - No reset.

Test Plan:
- Load 20 entries: op pattern W,R,W,W,R,R,R,R,W,W,W,R,R,W,R,W,R,W,R,R; start, num_entries=20; req_ready=1; rsp after 2 cycles, hit on even idx → done; reads=11, writes=9, hits=10, misses=10, bad_ops=0.
- Entries 2 and 5 with op 8'h41, num_entries=6 → exactly 4 requests issued; bad_ops=2, reads+writes=4.
- req_ready held low 5 cycles → req_valid and req_addr stable for those cycles; acceptance on the 6th; a single count.
- start with num_entries=0 → done the next cycle; req_valid never asserted; counters 0.
- Reset asserted while in WAIT_RSP → busy, done, counters and req_valid are 0 immediately. A new start without reload replays the same RAM contents.
- CNT_W=2, 8 reads all hits → num_reads=3, num_hits=3 (saturated); done=1.
